// File: rtl/miri_pkg.sv
// Shared encodings for the MIRI core: opcodes, ALU codes, instruction field
// positions and the decode control bundle.
package miri_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OPC_W   = 7;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned ALUOP_W = 2;

    localparam int unsigned OPC_LSB = 25;
    localparam int unsigned RD_LSB  = 20;
    localparam int unsigned RA_LSB  = 15;
    localparam int unsigned RB_LSB  = 10;

    localparam logic [OPC_W-1:0] OP_NOP  = 7'h00;
    localparam logic [OPC_W-1:0] OP_ADD  = 7'h01;
    localparam logic [OPC_W-1:0] OP_SUB  = 7'h02;
    localparam logic [OPC_W-1:0] OP_MUL  = 7'h03;
    localparam logic [OPC_W-1:0] OP_ADDI = 7'h04;
    localparam logic [OPC_W-1:0] OP_LDW  = 7'h10;
    localparam logic [OPC_W-1:0] OP_STW  = 7'h11;
    localparam logic [OPC_W-1:0] OP_BEQ  = 7'h30;

    localparam logic [ALUOP_W-1:0] ALU_ADD = 2'b00;
    localparam logic [ALUOP_W-1:0] ALU_SUB = 2'b01;
    localparam logic [ALUOP_W-1:0] ALU_MUL = 2'b10;

    localparam logic [INSTR_W-1:0] MIRI_NOP_WORD = 32'h0000_0000;

    // Control bundle produced by the opcode decoder; reads_* say which fields
    // the instruction actually sources (used for load-use detection).
    typedef struct packed {
        logic               alu_reg_dest;
        logic               is_branch;
        logic               mem_r_en;
        logic               mem_w_en;
        logic               mem_to_reg;
        logic               wb_en;
        logic               is_immediate;
        logic [ALUOP_W-1:0] alu_op;
        logic               reads_ra;
        logic               reads_rb;
        logic               reads_rd;
    } ctrl_t;

    function automatic logic [REG_W-1:0] reg_field(input logic [INSTR_W-1:0] instr,
                                                   input int unsigned        lsb);
        return instr[lsb +: REG_W];
    endfunction

endpackage

// File: rtl/control_decode.sv
// Pure combinational opcode-to-control mapping; unlisted opcodes decode as NOP.
module control_decode
    import miri_pkg::*;
(
    input  logic [OPC_W-1:0] opcode_i,
    output ctrl_t            ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (opcode_i)
            OP_ADD, OP_SUB, OP_MUL: begin
                ctrl_o.wb_en        = 1'b1;
                ctrl_o.alu_reg_dest = 1'b1;
                ctrl_o.reads_ra     = 1'b1;
                ctrl_o.reads_rb     = 1'b1;
                ctrl_o.alu_op       = (opcode_i == OP_ADD) ? ALU_ADD :
                                      (opcode_i == OP_SUB) ? ALU_SUB : ALU_MUL;
            end
            OP_ADDI: begin
                ctrl_o.wb_en        = 1'b1;
                ctrl_o.alu_reg_dest = 1'b1;
                ctrl_o.is_immediate = 1'b1;
                ctrl_o.alu_op       = ALU_ADD;
                ctrl_o.reads_ra     = 1'b1;
            end
            OP_LDW: begin
                ctrl_o.mem_r_en     = 1'b1;
                ctrl_o.mem_to_reg   = 1'b1;
                ctrl_o.wb_en        = 1'b1;
                ctrl_o.is_immediate = 1'b1;
                ctrl_o.alu_op       = ALU_ADD;
                ctrl_o.reads_ra     = 1'b1;
            end
            OP_STW: begin
                ctrl_o.mem_w_en     = 1'b1;
                ctrl_o.is_immediate = 1'b1;
                ctrl_o.alu_op       = ALU_ADD;
                ctrl_o.reads_ra     = 1'b1;
                ctrl_o.reads_rd     = 1'b1;
            end
            OP_BEQ: begin
                ctrl_o.is_branch    = 1'b1;
                ctrl_o.alu_op       = ALU_SUB;
                ctrl_o.reads_ra     = 1'b1;
                ctrl_o.reads_rd     = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/control.sv
// MIRI decode/pipeline control: field extraction, load-use tracking,
// stall priority (data-cache freeze > bubble > run) and bubble masking.
module control
    import miri_pkg::*;
#(
    parameter logic [INSTR_W-1:0] NOP_WORD = MIRI_NOP_WORD
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [INSTR_W-1:0]   instruction,
    input  logic                 block_pipe_data_cache,
    input  logic                 block_pipe_instr_cache,
    output logic                 ALU_REG_DEST,
    output logic                 is_branch,
    output logic                 MEM_R_EN,
    output logic                 MEM_W_EN,
    output logic                 MEM_TO_REG,
    output logic                 WB_EN,
    output logic [ALUOP_W-1:0]   ALU_OP,
    output logic [REG_W-1:0]     regA,
    output logic [REG_W-1:0]     regB,
    output logic [REG_W-1:0]     regD,
    output logic                 EN_REG_FETCH,
    output logic                 EN_REG_DECODE,
    output logic                 EN_REG_ALU,
    output logic                 EN_REG_MEM,
    output logic                 is_immediate,
    output logic [INSTR_W-1:0]   inject_nop,
    output logic                 injecting_nop
);

    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] rd, ra, rb;
    logic [9:0]       imm_low_unused;
    ctrl_t            dec;

    logic             ld_valid_q, ld_valid_d;
    logic [REG_W-1:0] ld_rd_q, ld_rd_d;
    logic             hazard, freeze, bubble, mask;

    assign opcode         = instruction[OPC_LSB +: OPC_W];
    assign rd             = reg_field(instruction, RD_LSB);
    assign ra             = reg_field(instruction, RA_LSB);
    assign rb             = reg_field(instruction, RB_LSB);
    assign imm_low_unused = instruction[9:0];

    control_decode u_decode (
        .opcode_i (opcode),
        .ctrl_o   (dec)
    );

    // Load-use: the previous load's destination is sourced by this instruction.
    always_comb begin
        hazard = ld_valid_q && (ld_rd_q != '0) &&
                 ((dec.reads_ra && (ld_rd_q == ra)) ||
                  (dec.reads_rb && (ld_rd_q == rb)) ||
                  (dec.reads_rd && (ld_rd_q == rd)));
    end

    always_comb begin
        freeze = !reset && block_pipe_data_cache;
        bubble = !reset && !block_pipe_data_cache && (hazard || block_pipe_instr_cache);
        mask   = reset || bubble;

        EN_REG_FETCH  = !freeze && !bubble;
        EN_REG_DECODE = !freeze && !bubble;
        EN_REG_ALU    = !freeze;
        EN_REG_MEM    = !freeze;
        injecting_nop = bubble;
        inject_nop    = NOP_WORD;

        ALU_REG_DEST  = mask ? 1'b0 : dec.alu_reg_dest;
        is_branch     = mask ? 1'b0 : dec.is_branch;
        MEM_R_EN      = mask ? 1'b0 : dec.mem_r_en;
        MEM_W_EN      = mask ? 1'b0 : dec.mem_w_en;
        MEM_TO_REG    = mask ? 1'b0 : dec.mem_to_reg;
        WB_EN         = mask ? 1'b0 : dec.wb_en;
        is_immediate  = mask ? 1'b0 : dec.is_immediate;
        ALU_OP        = mask ? ALUOP_W'(0) : dec.alu_op;

        regA = ra;
        regB = dec.reads_rd ? rd : rb;
        regD = rd;

        ld_valid_d = block_pipe_data_cache ? ld_valid_q : MEM_R_EN;
        ld_rd_d    = block_pipe_data_cache ? ld_rd_q    : rd;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_valid_q <= 1'b0;
            ld_rd_q    <= '0;
        end else begin
            ld_valid_q <= ld_valid_d;
            ld_rd_q    <= ld_rd_d;
        end
    end

endmodule

// File: tb/tb_control.sv
// Randomized bench for control: a table-driven reference of the MIRI ISA plus
// a tracked "last issued load" predicts every output each cycle.
module tb_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic        block_pipe_data_cache, block_pipe_instr_cache;
    logic        ALU_REG_DEST, is_branch, MEM_R_EN, MEM_W_EN, MEM_TO_REG, WB_EN;
    logic [1:0]  ALU_OP;
    logic [4:0]  regA, regB, regD;
    logic        EN_REG_FETCH, EN_REG_DECODE, EN_REG_ALU, EN_REG_MEM;
    logic        is_immediate;
    logic [31:0] inject_nop;
    logic        injecting_nop;

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic        m_ld_valid;
    logic [4:0]  m_ld_rd;
    logic        e_mem_r;

    control dut (
        .clk                    (clk),
        .reset                  (reset),
        .instruction            (instruction),
        .block_pipe_data_cache  (block_pipe_data_cache),
        .block_pipe_instr_cache (block_pipe_instr_cache),
        .ALU_REG_DEST           (ALU_REG_DEST),
        .is_branch              (is_branch),
        .MEM_R_EN               (MEM_R_EN),
        .MEM_W_EN               (MEM_W_EN),
        .MEM_TO_REG             (MEM_TO_REG),
        .WB_EN                  (WB_EN),
        .ALU_OP                 (ALU_OP),
        .regA                   (regA),
        .regB                   (regB),
        .regD                   (regD),
        .EN_REG_FETCH           (EN_REG_FETCH),
        .EN_REG_DECODE          (EN_REG_DECODE),
        .EN_REG_ALU             (EN_REG_ALU),
        .EN_REG_MEM             (EN_REG_MEM),
        .is_immediate           (is_immediate),
        .inject_nop             (inject_nop),
        .injecting_nop          (injecting_nop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                       input logic [4:0] ra, input logic [4:0] rb);
        return {op, rd, ra, rb, 10'd0};
    endfunction

    task automatic drive(input logic [31:0] ins, input logic dc, input logic ic, input logic rst);
        @(negedge clk);
        instruction            = ins;
        block_pipe_data_cache  = dc;
        block_pipe_instr_cache = ic;
        reset                  = rst;
        if (rst) begin
            m_ld_valid = 1'b0;
            m_ld_rd    = 5'd0;
        end
        #1;
    endtask

    // Predict every output from the ISA table and the remembered load.
    task automatic check_model();
        logic [6:0] op;
        logic [4:0] rd, ra, rb;
        logic       rda, rdb, rdd;
        logic [8:0] ctl;
        logic       hz, frz, bub;
        logic [3:0] en;
        op  = instruction[31:25];
        rd  = instruction[24:20];
        ra  = instruction[19:15];
        rb  = instruction[14:10];
        rda = 1'b0; rdb = 1'b0; rdd = 1'b0;
        // {alu_reg_dest,is_branch,mem_r,mem_w,mem_to_reg,wb,is_imm,alu_op}
        case (op)
            7'h01: begin ctl = 9'b1_0_0_0_0_1_0_00; rda = 1'b1; rdb = 1'b1; end
            7'h02: begin ctl = 9'b1_0_0_0_0_1_0_01; rda = 1'b1; rdb = 1'b1; end
            7'h03: begin ctl = 9'b1_0_0_0_0_1_0_10; rda = 1'b1; rdb = 1'b1; end
            7'h04: begin ctl = 9'b1_0_0_0_0_1_1_00; rda = 1'b1; end
            7'h10: begin ctl = 9'b0_0_1_0_1_1_1_00; rda = 1'b1; end
            7'h11: begin ctl = 9'b0_0_0_1_0_0_1_00; rda = 1'b1; rdd = 1'b1; end
            7'h30: begin ctl = 9'b0_1_0_0_0_0_0_01; rda = 1'b1; rdd = 1'b1; end
            default: ctl = 9'd0;
        endcase
        hz  = m_ld_valid && (m_ld_rd != 5'd0) &&
              ((rda && m_ld_rd == ra) || (rdb && m_ld_rd == rb) || (rdd && m_ld_rd == rd));
        frz = !reset && block_pipe_data_cache;
        bub = !reset && !frz && (hz || block_pipe_instr_cache);
        if (frz)      en = 4'b0000;
        else if (bub) en = 4'b0011;
        else          en = 4'b1111;
        if (reset || bub) ctl = 9'd0;
        e_mem_r = ctl[6];
        check("ctrl", 32'({ALU_REG_DEST, is_branch, MEM_R_EN, MEM_W_EN, MEM_TO_REG,
                           WB_EN, is_immediate, ALU_OP}), 32'(ctl));
        check("enables", 32'({EN_REG_FETCH, EN_REG_DECODE, EN_REG_ALU, EN_REG_MEM}), 32'(en));
        check("injecting", 32'(injecting_nop), 32'(bub));
        check("inject_word", inject_nop, 32'h0);
        check("regs", 32'({regA, regB, regD}), 32'({ra, (rdd ? rd : rb), rd}));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset && !block_pipe_data_cache) begin
            m_ld_valid = e_mem_r;
            m_ld_rd    = instruction[24:20];
        end
    endtask

    task automatic cycle(input logic [31:0] ins, input logic dc, input logic ic, input logic rst);
        drive(ins, dc, ic, rst);
        check_model();
        tick();
    endtask

    localparam logic [31:0] LDW_R5  = 32'h2050_8000;
    localparam logic [31:0] ADD_DEP = 32'h0262_8800;
    localparam logic [31:0] ADD_IND = 32'h0263_8800;
    localparam logic [31:0] ADD_R3  = 32'h0230_8800;

    initial begin
        logic [6:0] ops [8];
        logic [6:0] op;
        logic [31:0] ins;
        ops[0] = 7'h00; ops[1] = 7'h01; ops[2] = 7'h02; ops[3] = 7'h03;
        ops[4] = 7'h04; ops[5] = 7'h10; ops[6] = 7'h11; ops[7] = 7'h30;
        m_ld_valid = 1'b0; m_ld_rd = 5'd0; e_mem_r = 1'b0;
        reset = 1'b1; instruction = 32'h0;
        block_pipe_data_cache = 1'b0; block_pipe_instr_cache = 1'b0;

        // Reset, then NOP decode
        drive(ADD_R3, 1'b1, 1'b1, 1'b1);
        check_model();
        check("rst_en", 32'({EN_REG_FETCH, EN_REG_DECODE, EN_REG_ALU, EN_REG_MEM}), 32'hF);
        check("rst_wb", 32'(WB_EN), 32'h0);
        tick();
        cycle(32'h0, 1'b0, 1'b0, 1'b1);
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        check_model();
        check("nop_injecting", 32'(injecting_nop), 32'h0);
        tick();

        // ADD r3,r1,r2
        drive(ADD_R3, 1'b0, 1'b0, 1'b0);
        check_model();
        check("add_wb", 32'({WB_EN, ALU_REG_DEST, ALU_OP}), 32'b1100);
        check("add_regs", 32'({regA, regB, regD}), 32'({5'd1, 5'd2, 5'd3}));
        tick();

        // Load-use: exactly one bubble
        cycle(LDW_R5, 1'b0, 1'b0, 1'b0);
        drive(ADD_DEP, 1'b0, 1'b0, 1'b0);
        check_model();
        check("lu_bubble", 32'({injecting_nop, EN_REG_FETCH, EN_REG_DECODE, WB_EN}), 32'b1000);
        tick();
        drive(ADD_DEP, 1'b0, 1'b0, 1'b0);
        check_model();
        check("lu_after", 32'({injecting_nop, WB_EN}), 32'b01);
        tick();

        // No dependency, and load to r0
        cycle(LDW_R5, 1'b0, 1'b0, 1'b0);
        drive(ADD_IND, 1'b0, 1'b0, 1'b0);
        check_model();
        check("nodep", 32'(injecting_nop), 32'h0);
        tick();
        cycle(mk(7'h10, 5'd0, 5'd1, 5'd0), 1'b0, 1'b0, 1'b0);
        drive(mk(7'h01, 5'd6, 5'd0, 5'd0), 1'b0, 1'b0, 1'b0);
        check_model();
        check("ld_r0", 32'(injecting_nop), 32'h0);
        tick();

        // Data-cache freeze holds the load across edges, hazard returns on release
        cycle(LDW_R5, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(ADD_DEP, 1'b1, 1'b1, 1'b0);
            check_model();
            check("frz", 32'({EN_REG_FETCH, EN_REG_DECODE, EN_REG_ALU, EN_REG_MEM,
                              injecting_nop, WB_EN}), 32'b000001);
            tick();
        end
        drive(ADD_DEP, 1'b0, 1'b0, 1'b0);
        check_model();
        check("frz_release", 32'(injecting_nop), 32'h1);
        tick();

        // Instruction-cache miss with STW
        drive(mk(7'h11, 5'd4, 5'd2, 5'd9), 1'b0, 1'b1, 1'b0);
        check_model();
        check("ic_stw", 32'({MEM_W_EN, injecting_nop, EN_REG_ALU}), 32'b011);
        tick();

        // Reset asserted mid-hazard clears it at once
        cycle(LDW_R5, 1'b0, 1'b0, 1'b0);
        drive(ADD_DEP, 1'b0, 1'b0, 1'b0);
        check("pre_rst", 32'(injecting_nop), 32'h1);
        reset = 1'b1; m_ld_valid = 1'b0; m_ld_rd = 5'd0;
        #1;
        check_model();
        check("mid_rst", 32'(injecting_nop), 32'h0);
        tick();
        drive(ADD_DEP, 1'b0, 1'b0, 1'b0);
        check_model();
        check("post_rst", 32'({injecting_nop, WB_EN}), 32'b01);
        tick();

        // Random traffic
        for (int n = 0; n < 800; n++) begin
            op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 7)];
            ins = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 10'($urandom)};
            cycle(ins, ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 10),
                  ($urandom_range(0, 99) < 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control.md
Name: control

Overview:
- Instruction decode and pipeline-control unit of the MIRI pipelined core.
- Decodes the 32-bit instruction in the decode stage into datapath control signals and register indices.
- Drives per-stage pipeline-register enables, stalling or bubbling on cache blocks and load-use hazards.
- Tracks only the previously issued load; everything else is combinational.

Parameters:
- NOP_WORD, 32'h0000_0000, encoding driven on inject_nop.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- instruction  in  32  instruction currently in decode.
- block_pipe_data_cache  in  1  data-cache miss; freeze whole pipe.
- block_pipe_instr_cache  in  1  instruction-cache miss; decode word invalid.
- ALU_REG_DEST  out  1  ALU result is the register write-back value.
- is_branch  out  1  conditional branch (BEQ).
- MEM_R_EN  out  1  data-memory read.
- MEM_W_EN  out  1  data-memory write.
- MEM_TO_REG  out  1  write-back selects memory data.
- WB_EN  out  1  register-file write enable.
- ALU_OP  out  2  00 add, 01 sub, 10 mul, 11 reserved (never driven).
- regA, regB, regD  out  5 each  source A, source B, destination indices.
- EN_REG_FETCH, EN_REG_DECODE, EN_REG_ALU, EN_REG_MEM  out  1 each  pipeline-register load enables (fetch enable also holds PC).
- is_immediate  out  1  ALU operand B is sign-extended instr[14:0].
- inject_nop  out  32  constant NOP_WORD.
- injecting_nop  out  1  decode outputs replaced by a bubble this cycle.

Behaviour:
- Fields: opcode=instr[31:25], rd=[24:20], ra=[19:15], rb=[14:10], imm=[14:0].
  - regA=ra, regD=rd always.
  - regB=rd for STW/BEQ, else rb.
- Opcodes (unlisted decode as NOP):
  - 00 NOP: all controls 0.
  - 01 ADD / 02 SUB / 03 MUL: WB_EN=1, ALU_REG_DEST=1, ALU_OP=00/01/10; read ra, rb.
  - 04 ADDI: WB_EN=1, ALU_REG_DEST=1, is_immediate=1, ALU_OP=00; read ra.
  - 10 LDW: MEM_R_EN=1, MEM_TO_REG=1, WB_EN=1, is_immediate=1, ALU_OP=00; read ra.
  - 11 STW: MEM_W_EN=1, is_immediate=1, ALU_OP=00; read ra, rd.
  - 30 BEQ: is_branch=1, ALU_OP=01; read ra, rd.
- Load-use hazard: ld_valid && ld_rd!=0 && ld_rd equals a register the current opcode actually reads.
- Stall priority, highest first:
  1. block_pipe_data_cache: all four EN_REG_*=0, injecting_nop=0, decode outputs unmasked.
  2. Load-use hazard or block_pipe_instr_cache: EN_REG_FETCH=0, EN_REG_DECODE=0, EN_REG_ALU=1, EN_REG_MEM=1, injecting_nop=1.
  3. Otherwise all enables 1, injecting_nop=0.
- When injecting_nop=1: ALU_REG_DEST, is_branch, MEM_R_EN, MEM_W_EN, MEM_TO_REG, WB_EN, is_immediate and ALU_OP forced 0. regA/regB/regD still reflect the fields.
- Tracking registers ld_valid, ld_rd:
  - Update on rising clk when block_pipe_data_cache=0: ld_valid<=final MEM_R_EN, ld_rd<=regD.
  - Hold otherwise.
  - A bubble therefore clears the hazard the next cycle (exactly one bubble per load-use).
- Reset (async, active-high): ld_valid=0, ld_rd=0 immediately. While reset=1:
  - decoded controls forced 0;
  - all EN_REG_*=1;
  - injecting_nop=0;
  - inject_nop=NOP_WORD.
- Data-cache block and hazard simultaneous: freeze wins; the hazard is re-evaluated after release.
- Hazard and instr-cache block simultaneous: a single bubble cycle.

Decomposition:
- Package miri_pkg:
  - opcode localparams;
  - ALU_OP codes;
  - field bit positions;
  - NOP_WORD.
- Optional sub-module control_decode: pure combinational opcode to control mapping.
- The top level holds the hazard tracking, stall priority and masking.

Test Plan:
- Reset, then instruction=32'h0 -> all controls 0; enables 1; injecting_nop=0; inject_nop=32'h0.
- ADD r3,r1,r2 (0x0230_8800) -> WB_EN=1, ALU_REG_DEST=1, ALU_OP=00, regA=1, regB=2, regD=3.
- LDW r5,0(r1) at one edge, then ADD r6,r5,r2 -> one cycle with injecting_nop=1, EN_REG_FETCH/DECODE=0, WB_EN=0. The next cycle is normal with ADD decoded.
- LDW r5 then ADD r6,r7,r2 (no dependency), or a load to r0 -> no bubble.
- block_pipe_data_cache=1 with any instruction -> all EN_REG_*=0 and ld state held across edges. Release -> resume.
- block_pipe_instr_cache=1 with STW -> MEM_W_EN=0, injecting_nop=1, EN_REG_ALU=1. Assert reset mid-hazard -> hazard cleared asynchronously.
